// File: rtl/video_frame_capture_pkg.sv
// Shared video timing constants and capture FSM state type.
package video_pkg;

    localparam int unsigned H_SYNC  = 40;
    localparam int unsigned H_BACK  = 220;
    localparam int unsigned H_DISP  = 1280;
    localparam int unsigned H_FRONT = 110;
    localparam int unsigned H_TOTAL = 1650;

    localparam int unsigned V_SYNC  = 5;
    localparam int unsigned V_BACK  = 20;
    localparam int unsigned V_DISP  = 720;
    localparam int unsigned V_FRONT = 5;
    localparam int unsigned V_TOTAL = 750;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } cap_state_t;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/video_frame_capture_if.sv
// Pixel-stream input and frame-buffer write port of the capture block.
interface video_frame_capture_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 20
);
    logic              in_vsync;
    logic              in_hsync;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // Stream source / frame-buffer side.
    modport master (
        output in_vsync, in_hsync, in_valid, in_data,
        input  wr_en, wr_addr, wr_data
    );

    // Capture block side.
    modport slave (
        input  in_vsync, in_hsync, in_valid, in_data,
        output wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/video_sync_edge.sv
// Registers vsync/valid once and derives the frame-start, line-end and pixel qualifiers.
module video_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic in_vsync,
    input  logic in_valid,
    output logic vs_rise_c,
    output logic va_fall_c,
    output logic pixel_ok_c
);

    logic vs_d;
    logic va_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d <= 1'b0;
            va_d <= 1'b0;
        end else begin
            vs_d <= in_vsync;
            va_d <= in_valid;
        end
    end

    assign vs_rise_c  = in_vsync & ~vs_d;
    assign va_fall_c  = ~in_valid & va_d;
    assign pixel_ok_c = in_valid & ~in_vsync;

endmodule

// File: rtl/video_frame_capture.sv
// Frame-capture sink: locks to a frame on vsync and turns active pixels into linear
// frame-buffer writes, with frame pulses, a frame counter and sticky length errors.
module video_frame_capture #(
    parameter int unsigned H_DISP = video_pkg::H_DISP,
    parameter int unsigned V_DISP = video_pkg::V_DISP,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    video_frame_capture_if.slave   bus,
    input  logic                   capture_en,
    output logic                   frame_start,
    output logic                   frame_done,
    output logic                   busy,
    output logic [15:0]            frame_cnt,
    output logic                   err_line_len,
    output logic                   err_frame_len
);

    import video_pkg::*;

    localparam int unsigned COL_W = cnt_w(H_DISP + 1);
    localparam int unsigned ROW_W = cnt_w(V_DISP);

    logic vs_rise;
    logic va_fall;
    logic pixel_ok;

    video_sync_edge u_sync_edge (
        .clk        (clk),
        .rst        (rst),
        .in_vsync   (bus.in_vsync),
        .in_valid   (bus.in_valid),
        .vs_rise_c  (vs_rise),
        .va_fall_c  (va_fall),
        .pixel_ok_c (pixel_ok)
    );

    cap_state_t        state, state_nxt;
    logic [COL_W-1:0]  col, col_nxt;
    logic [ROW_W-1:0]  row, row_nxt;
    logic [ADDR_W-1:0] line_base, base_nxt;
    logic              wr_en_q, wr_en_nxt;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_nxt;
    logic [DATA_W-1:0] wr_data_q, wr_data_nxt;
    logic              start_nxt, done_nxt, busy_nxt;
    logic [15:0]       cnt_nxt;
    logic              err_line_nxt, err_frame_nxt;
    logic              frame_closed;
    logic              lock;

    // State and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            col           <= '0;
            row           <= '0;
            line_base     <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_start   <= 1'b0;
            frame_done    <= 1'b0;
            busy          <= 1'b0;
            frame_cnt     <= '0;
            err_line_len  <= 1'b0;
            err_frame_len <= 1'b0;
        end else begin
            state         <= state_nxt;
            col           <= col_nxt;
            row           <= row_nxt;
            line_base     <= base_nxt;
            wr_en_q       <= wr_en_nxt;
            wr_addr_q     <= wr_addr_nxt;
            wr_data_q     <= wr_data_nxt;
            frame_start   <= start_nxt;
            frame_done    <= done_nxt;
            busy          <= busy_nxt;
            frame_cnt     <= cnt_nxt;
            err_line_len  <= err_line_nxt;
            err_frame_len <= err_frame_nxt;
        end
    end

    // Next-state, pixel addressing and line/frame bookkeeping.
    always_comb begin
        state_nxt     = state;
        col_nxt       = col;
        row_nxt       = row;
        base_nxt      = line_base;
        wr_en_nxt     = 1'b0;
        wr_addr_nxt   = wr_addr_q;
        wr_data_nxt   = wr_data_q;
        start_nxt     = 1'b0;
        done_nxt      = 1'b0;
        cnt_nxt       = frame_cnt;
        err_line_nxt  = err_line_len;
        err_frame_nxt = err_frame_len;
        frame_closed  = 1'b0;
        lock          = 1'b0;

        unique case (state)
            // Flags clear only on a fresh arm, so they stay sticky across back-to-back frames.
            IDLE: begin
                if (capture_en) begin
                    state_nxt     = ARMED;
                    err_line_nxt  = 1'b0;
                    err_frame_nxt = 1'b0;
                end
            end
            ARMED: begin
                if (vs_rise) lock = 1'b1;
            end
            CAPTURE: begin
                if (pixel_ok) begin
                    if (col < COL_W'(H_DISP)) begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = line_base + ADDR_W'(col);
                        wr_data_nxt = bus.in_data;
                        col_nxt     = col + COL_W'(1);
                    end else begin
                        err_line_nxt = 1'b1;
                    end
                end
                if (va_fall) begin
                    if (col != COL_W'(H_DISP)) err_line_nxt = 1'b1;
                    col_nxt  = '0;
                    base_nxt = line_base + ADDR_W'(H_DISP);
                    if (row == ROW_W'(V_DISP - 1)) begin
                        done_nxt     = 1'b1;
                        cnt_nxt      = frame_cnt + 16'd1;
                        frame_closed = 1'b1;
                        state_nxt    = capture_en ? ARMED : IDLE;
                    end else begin
                        row_nxt = row + ROW_W'(1);
                    end
                end
                // A vsync that coincides with the closing line starts the next frame cleanly.
                if (vs_rise) begin
                    if (!frame_closed) begin
                        err_frame_nxt = 1'b1;
                        lock          = 1'b1;
                    end else if (capture_en) begin
                        lock = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (lock) begin
            state_nxt = CAPTURE;
            start_nxt = 1'b1;
            row_nxt   = '0;
            col_nxt   = '0;
            base_nxt  = '0;
        end

        busy_nxt = (state_nxt != IDLE);
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

endmodule
